// File: rtl/kmap_sweep_engine.sv
// Truth-table sweeper: walks every input combination of an external
// combinational function, captures its response and scores it against an expected table.
module kmap_sweep_engine #(
    parameter  int NVARS = 4,
    localparam int TT_W  = 2 ** NVARS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             check_en_i,
    input  logic [TT_W-1:0]  expected_tt_i,
    input  logic             f_in_i,
    output logic [NVARS-1:0] var_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [NVARS:0]   mismatch_count_o,
    output logic [NVARS-1:0] first_fail_idx_o,
    output logic [NVARS:0]   ones_count_o,
    output logic [TT_W-1:0]  captured_tt_o
);

    localparam int CW = NVARS + 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [NVARS-1:0] idx_q, idx_d;
    logic [TT_W-1:0]  exp_q, exp_d;
    logic             chk_q, chk_d;
    logic [TT_W-1:0]  capt_q, capt_d;
    logic [CW-1:0]    ones_q, ones_d;
    logic [CW-1:0]    mism_q, mism_d;
    logic [NVARS-1:0] ffi_q, ffi_d;
    logic             pass_q, pass_d;

    // NOTE: every _d gets its hold value first so no path leaves a signal
    // unassigned (no latch); blocking '=' lets later lines see updated _d values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        exp_d   = exp_q;
        chk_d   = chk_q;
        capt_d  = capt_q;
        ones_d  = ones_q;
        mism_d  = mism_q;
        ffi_d   = ffi_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    exp_d   = expected_tt_i;
                    chk_d   = check_en_i;
                    capt_d  = '0;
                    ones_d  = '0;
                    mism_d  = '0;
                    ffi_d   = '0;
                    pass_d  = 1'b0;
                end
            end

            SWEEP: begin
                capt_d[idx_q] = f_in_i;
                if (f_in_i) begin
                    ones_d = ones_q + CW'(1);
                end
                if (chk_q && (f_in_i != exp_q[idx_q])) begin
                    // Only the lowest failing minterm is recorded.
                    if (mism_q == '0) begin
                        ffi_d = idx_q;
                    end
                    mism_d = mism_q + CW'(1);
                end
                if (&idx_q) begin
                    state_d = DONE;
                    idx_d   = '0;
                    pass_d  = (mism_d == '0);
                end else begin
                    idx_d = idx_q + NVARS'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking '<=' and a synchronous reset that
    // clears the whole result set, not just the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
            chk_q   <= 1'b0;
            capt_q  <= '0;
            ones_q  <= '0;
            mism_q  <= '0;
            ffi_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            chk_q   <= chk_d;
            capt_q  <= capt_d;
            ones_q  <= ones_d;
            mism_q  <= mism_d;
            ffi_q   <= ffi_d;
            pass_q  <= pass_d;
        end
    end

    // f_in_i answers var_out_o in the same cycle, so var_out_o is driven straight from idx.
    assign var_out_o        = (state_q == SWEEP) ? idx_q : '0;
    assign busy_o           = (state_q == SWEEP);
    assign done_o           = (state_q == DONE);
    assign pass_o           = pass_q;
    assign mismatch_count_o = mism_q;
    assign first_fail_idx_o = ffi_q;
    assign ones_count_o     = ones_q;
    assign captured_tt_o    = capt_q;

endmodule

// File: tb/tb_kmap_sweep_engine.sv
// Scoreboard bench for kmap_sweep_engine: a 4-variable and a 2-variable instance,
// each sweeping a bench-side truth table that answers var_out combinationally.
module tb_kmap_sweep_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // NVARS=4 instance
    logic        start4 = 1'b0, chk4 = 1'b0;
    logic [15:0] exp4 = '0, ftab4 = '0;
    logic [3:0]  var4, ffi4;
    logic [4:0]  mism4, ones4;
    logic [15:0] capt4;
    logic        busy4, done4, pass4, f4;
    assign f4 = ftab4[var4];

    // NVARS=2 instance
    logic        start2 = 1'b0, chk2 = 1'b0;
    logic [3:0]  exp2 = '0, ftab2 = '0;
    logic [1:0]  var2, ffi2;
    logic [2:0]  mism2, ones2;
    logic [3:0]  capt2;
    logic        busy2, done2, pass2, f2;
    assign f2 = ftab2[var2];

    kmap_sweep_engine #(.NVARS(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .check_en_i(chk4),
        .expected_tt_i(exp4), .f_in_i(f4), .var_out_o(var4), .busy_o(busy4),
        .done_o(done4), .pass_o(pass4), .mismatch_count_o(mism4),
        .first_fail_idx_o(ffi4), .ones_count_o(ones4), .captured_tt_o(capt4)
    );

    kmap_sweep_engine #(.NVARS(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .check_en_i(chk2),
        .expected_tt_i(exp2), .f_in_i(f2), .var_out_o(var2), .busy_o(busy2),
        .done_o(done2), .pass_o(pass2), .mismatch_count_o(mism2),
        .first_fail_idx_o(ffi2), .ones_count_o(ones2), .captured_tt_o(capt2)
    );

    // Zero-extended view of whichever instance is selected.
    logic        sel = 1'b0;
    logic [3:0]  o_var, o_ffi;
    logic [4:0]  o_mism, o_ones;
    logic [15:0] o_capt;
    logic        o_busy, o_done, o_pass;
    always_comb begin
        o_var  = sel ? {2'b00, var2}   : var4;
        o_ffi  = sel ? {2'b00, ffi2}   : ffi4;
        o_mism = sel ? {2'b00, mism2}  : mism4;
        o_ones = sel ? {2'b00, ones2}  : ones4;
        o_capt = sel ? {12'h000, capt2} : capt4;
        o_busy = sel ? busy2 : busy4;
        o_done = sel ? done2 : done4;
        o_pass = sel ? pass2 : pass4;
    end

    typedef struct {
        logic        pass;
        logic [4:0]  mism;
        logic [3:0]  ffi;
        logic [4:0]  ones;
        logic [15:0] capt;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic res_t model(input logic [15:0] exp, input logic [15:0] ft,
                                   input logic chk, input int n);
        res_t r;
        r.pass = 1'b0;
        r.mism = '0;
        r.ffi  = '0;
        r.ones = '0;
        r.capt = '0;
        for (int i = 0; i < n; i++) begin
            r.capt[i] = ft[i];
            if (ft[i]) r.ones = r.ones + 5'd1;
            if (chk && (ft[i] != exp[i])) begin
                if (r.mism == 5'd0) r.ffi = 4'(i);
                r.mism = r.mism + 5'd1;
            end
        end
        r.pass = (r.mism == 5'd0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep, follow it cycle by cycle, then score the done cycle and the idle hold.
    task automatic run_sweep(input logic s, input logic [15:0] exp, input logic [15:0] ft,
                             input logic chk, input logic hold, input string name);
        int   n;
        res_t e;
        n   = s ? 4 : 16;
        sel = s;
        if (s) begin
            exp2 = exp[3:0]; ftab2 = ft[3:0]; chk2 = chk; start2 = 1'b1;
        end else begin
            exp4 = exp; ftab4 = ft; chk4 = chk; start4 = 1'b1;
        end
        sb.push_back(model(exp, ft, chk, n));
        tick();
        if (!hold) begin
            start2 = 1'b0;
            start4 = 1'b0;
        end
        for (int c = 1; c <= n; c++) begin
            checks++;
            if (o_busy !== 1'b1 || o_done !== 1'b0 || o_var !== 4'(c - 1)) begin
                errors++;
                $display("FAIL %s sweep cycle %0d: busy=%b done=%b var_out=%0d, want busy=1 done=0 var_out=%0d",
                         name, c, o_busy, o_done, o_var, c - 1);
            end
            tick();
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: queue empty at done, want one entry", name);
            e = model(exp, ft, chk, n);
        end else begin
            e = sb.pop_front();
        end
        // Phase 0 is the done cycle; phase 1 is the following idle cycle, with start
        // still high when holding to show that DONE ignores it.
        for (int ph = 0; ph < 2; ph++) begin
            checks++;
            if (o_done !== (ph == 0) || o_busy !== 1'b0 || o_var !== 4'd0) begin
                errors++;
                $display("FAIL %s ctrl ph%0d: done=%b busy=%b var_out=%0d, want done=%b busy=0 var_out=0",
                         name, ph, o_done, o_busy, o_var, (ph == 0));
            end
            checks++;
            if (o_pass !== e.pass) begin
                errors++;
                $display("FAIL %s pass ph%0d: got %b want %b", name, ph, o_pass, e.pass);
            end
            checks++;
            if (o_mism !== e.mism) begin
                errors++;
                $display("FAIL %s mismatch_count ph%0d: got %0d want %0d", name, ph, o_mism, e.mism);
            end
            checks++;
            if (o_ffi !== e.ffi) begin
                errors++;
                $display("FAIL %s first_fail_idx ph%0d: got %0d want %0d", name, ph, o_ffi, e.ffi);
            end
            checks++;
            if (o_ones !== e.ones) begin
                errors++;
                $display("FAIL %s ones_count ph%0d: got %0d want %0d", name, ph, o_ones, e.ones);
            end
            checks++;
            if (o_capt !== e.capt) begin
                errors++;
                $display("FAIL %s captured_tt ph%0d: got %h want %h", name, ph, o_capt, e.capt);
            end
            if (ph == 0) begin
                tick();
                start2 = 1'b0;
                start4 = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({o_var, o_busy, o_done, o_pass, o_mism, o_ffi, o_ones, o_capt} !== '0) begin
                errors++;
                $display("FAIL reset inst%0d: var=%0d busy=%b done=%b pass=%b mism=%0d ffi=%0d ones=%0d capt=%h, want all 0",
                         s, o_var, o_busy, o_done, o_pass, o_mism, o_ffi, o_ones, o_capt);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_match();
        run_sweep(1'b0, 16'hE8E8, 16'hE8E8, 1'b1, 1'b0, "match");
    endtask

    task automatic test_mismatch();
        run_sweep(1'b0, 16'hE8E9, 16'hE8E8, 1'b1, 1'b0, "mis_bit0");
        run_sweep(1'b0, 16'hA8E8, 16'hE8E8, 1'b1, 1'b0, "mis_bit14");
        run_sweep(1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, "all_fail");
    endtask

    task automatic test_abort_reset();
        sel   = 1'b0;
        exp4  = 16'hE8E8;
        ftab4 = 16'hE8E8;
        chk4  = 1'b1;
        start4 = 1'b1;
        tick();
        repeat (4) tick();
        checks++;
        if (o_busy !== 1'b1 || o_var !== 4'd4) begin
            errors++;
            $display("FAIL abort pre-reset: busy=%b var_out=%0d, want busy=1 var_out=4", o_busy, o_var);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({o_var, o_busy, o_done, o_pass, o_mism, o_ffi, o_ones, o_capt} !== '0) begin
            errors++;
            $display("FAIL abort reset: var=%0d busy=%b done=%b pass=%b mism=%0d ffi=%0d ones=%0d capt=%h, want all 0",
                     o_var, o_busy, o_done, o_pass, o_mism, o_ffi, o_ones, o_capt);
        end
        rst = 1'b0;
        // start is still high: the next edge begins a clean sweep, and holding
        // start through SWEEP and DONE must not restart it.
        run_sweep(1'b0, 16'hE8E8, 16'hE8E8, 1'b1, 1'b1, "after_reset");
    endtask

    task automatic test_capture_only();
        run_sweep(1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0, "capture_only");
    endtask

    task automatic test_nvars2();
        run_sweep(1'b1, 16'h0006, 16'h0006, 1'b1, 1'b0, "n2_xor");
        run_sweep(1'b1, 16'h0009, 16'h0006, 1'b1, 1'b0, "n2_xnor_exp");
    endtask

    task automatic test_back_to_back();
        run_sweep(1'b0, 16'h8001, 16'h8001, 1'b1, 1'b0, "b2b_a");
        run_sweep(1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0, "b2b_b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_abort_reset();
        test_capture_only();
        test_nvars2();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
